// File: rtl/sid_pkg.sv
// Shared SID types and I2S frame constants.
package sid;
    localparam int I2S_FRAME_BITS  = 64;
    localparam int I2S_SLOT_BITS   = 32;
    localparam int I2S_SAMPLE_BITS = 24;
    localparam int I2S_PAD_BITS    = I2S_SLOT_BITS - I2S_SAMPLE_BITS - 1;

    typedef struct packed {
        logic signed [I2S_SAMPLE_BITS-1:0] left;
        logic signed [I2S_SAMPLE_BITS-1:0] right;
    } audio_t;

    // Each slot: one idle bit ahead of the MSB, then the sample, then zero pad.
    function automatic logic [I2S_FRAME_BITS-1:0] i2s_frame(audio_t a);
        return {1'b0, a.left, {I2S_PAD_BITS{1'b0}}, 1'b0, a.right, {I2S_PAD_BITS{1'b0}}};
    endfunction
endpackage

// File: rtl/sid_i2s_tx_if.sv
// Sample input and I2S/status outputs of the SID I2S transmitter.
interface sid_i2s_tx_if;
    import sid::*;

    audio_t audio_i;
    logic   valid_i;
    logic   i2s_sck;
    logic   i2s_ws;
    logic   i2s_sd;
    logic   frame_o;
    logic   underrun_o;
    logic   overrun_o;

    modport master (
        output audio_i, valid_i,
        input  i2s_sck, i2s_ws, i2s_sd, frame_o, underrun_o, overrun_o
    );

    modport slave (
        input  audio_i, valid_i,
        output i2s_sck, i2s_ws, i2s_sd, frame_o, underrun_o, overrun_o
    );
endinterface

// File: rtl/sid_i2s_sckgen.sv
// Bit-clock divider: SCK toggles every BCLK_DIV clk cycles, first toggle rising.
module sid_i2s_sckgen #(
    parameter int BCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic sck_o,
    output logic fall_o,
    output logic rise_o
);
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic          tick;

    assign tick = (div_cnt == DW'(BCLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            sck_o   <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            sck_o   <= ~sck_o;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Strobes mark the clk edge at which sck_o is about to toggle.
    assign fall_o = tick & sck_o;
    assign rise_o = tick & ~sck_o;
endmodule

// File: rtl/sid_i2s_tx.sv
// I2S master transmitter: double-buffered stereo sample, 64-bit frame shifter.
module sid_i2s_tx
    import sid::*;
#(
    parameter int BCLK_DIV   = 2,
    parameter int FRAME_BITS = I2S_FRAME_BITS
) (
    input  logic         clk,
    input  logic         rst,
    sid_i2s_tx_if.slave  bus
);
    localparam int BW = $clog2(FRAME_BITS);

    logic                  sck, fall, rise;
    logic [BW-1:0]         b, b_nxt;
    logic [FRAME_BITS-1:0] shifter;
    audio_t                hold;
    logic                  fresh, load;
    logic                  ws, frame_q, under_q, over_q;
    logic                  rise_seen;

    sid_i2s_sckgen #(.BCLK_DIV(BCLK_DIV)) u_sckgen (
        .clk    (clk),
        .rst    (rst),
        .sck_o  (sck),
        .fall_o (fall),
        .rise_o (rise)
    );

    assign b_nxt = b + BW'(1);
    assign load  = fall && (b == BW'(FRAME_BITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            b         <= '1;
            shifter   <= '0;
            hold      <= '0;
            fresh     <= 1'b0;
            ws        <= 1'b0;
            frame_q   <= 1'b0;
            under_q   <= 1'b0;
            over_q    <= 1'b0;
            rise_seen <= 1'b0;
        end else begin
            frame_q <= load;
            under_q <= load & ~fresh;
            over_q  <= bus.valid_i & fresh & ~load;
            if (rise)
                rise_seen <= 1'b1;
            if (fall) begin
                b  <= b_nxt;
                // WS leads each slot's MSB by one bit: high for b = 31..62.
                ws <= (b_nxt >= BW'(I2S_SLOT_BITS - 1)) && (b_nxt != BW'(FRAME_BITS - 1));
                if (load)
                    shifter <= i2s_frame(hold);
                else
                    shifter <= {shifter[FRAME_BITS-2:0], 1'b0};
            end
            // The load above captures the old holding value; a same-cycle sample
            // lands afterwards as fresh and is not counted as an overrun.
            if (bus.valid_i) begin
                hold  <= bus.audio_i;
                fresh <= 1'b1;
            end else if (load) begin
                fresh <= 1'b0;
            end
        end
    end

    assign bus.i2s_sck    = sck;
    assign bus.i2s_ws     = ws;
    assign bus.i2s_sd     = shifter[FRAME_BITS-1] & rise_seen;
    assign bus.frame_o    = frame_q;
    assign bus.underrun_o = under_q;
    assign bus.overrun_o  = over_q;
endmodule

// File: tb/tb_sid_i2s_tx.sv
// Directed bench: BCLK_DIV=2 instance for framing/buffering, BCLK_DIV=1 for mid-frame reset.
module tb_sid_i2s_tx;
    import sid::*;

    logic clk = 1'b0;
    logic rst1 = 1'b1;
    logic rst2 = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   ovr2 = 0;

    // WS per bit (bit 63 = b0): high for b = 31..62.
    localparam logic [63:0] WS_PAT = 64'h0000_0001_FFFF_FFFE;

    sid_i2s_tx_if if1();
    sid_i2s_tx_if if2();

    sid_i2s_tx #(.BCLK_DIV(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1));
    sid_i2s_tx #(.BCLK_DIV(2)) dut2 (.clk(clk), .rst(rst2), .bus(if2));

    always #5 clk = ~clk;

    always @(negedge clk) if (if2.overrun_o) ovr2 <= ovr2 + 1;

    function automatic logic [63:0] exp_frame(input logic [23:0] l, input logic [23:0] r);
        return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
    endfunction

    task automatic pulse(input bit sel, input logic [23:0] l, input logic [23:0] r);
        if (sel) begin
            if1.audio_i = {l, r}; if1.valid_i = 1'b1;
            @(negedge clk); if1.valid_i = 1'b0;
        end else begin
            if2.audio_i = {l, r}; if2.valid_i = 1'b1;
            @(negedge clk); if2.valid_i = 1'b0;
        end
    endtask

    // Waits for frame_o, then records sd/ws at each of the 64 SCK rising edges.
    task automatic capture(input bit sel, output logic [63:0] sdb, output logic [63:0] wsb,
                           output logic und, output bit ok);
        int n, j;
        logic prev, s;
        ok = 1'b0; sdb = '0; wsb = '0; und = 1'b0; n = 0; j = 0;
        while (!(sel ? if1.frame_o : if2.frame_o) && n < 600) begin
            @(negedge clk); n++;
        end
        if (n >= 600) return;
        und  = sel ? if1.underrun_o : if2.underrun_o;
        prev = sel ? if1.i2s_sck : if2.i2s_sck;
        n = 0;
        while (j < 64 && n < 600) begin
            @(negedge clk); n++;
            s = sel ? if1.i2s_sck : if2.i2s_sck;
            if (s && !prev) begin
                sdb[63-j] = sel ? if1.i2s_sd : if2.i2s_sd;
                wsb[63-j] = sel ? if1.i2s_ws : if2.i2s_ws;
                j++;
            end
            prev = s;
        end
        ok = (j == 64);
    endtask

    task automatic test_reset();
        logic [5:0] o;
        logic [6:1] sck_exp;
        sck_exp = 6'b100110;  // cycles 6..1: 1,0,0,1,1,0
        repeat (3) @(negedge clk);
        o = {if2.i2s_sck, if2.i2s_ws, if2.i2s_sd, if2.frame_o, if2.underrun_o, if2.overrun_o};
        checks++;
        if (o !== 6'b0) begin errors++; $display("FAIL reset_outputs got=%b exp=000000", o); end
        rst2 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (if2.i2s_sck !== sck_exp[k] || if2.frame_o !== (k == 4) || if2.underrun_o !== (k == 4)
                || if2.i2s_sd !== 1'b0) begin
                errors++;
                $display("FAIL startup_cycle%0d sck=%b frame=%b under=%b sd=%b exp sck=%b frame/under=%b sd=0",
                         k, if2.i2s_sck, if2.frame_o, if2.underrun_o, if2.i2s_sd, sck_exp[k], k == 4);
            end
        end
    endtask

    task automatic test_idle_frame();
        logic [63:0] sdb, wsb; logic und; bit ok;
        capture(0, sdb, wsb, und, ok);
        checks++; if (!ok) begin errors++; $display("FAIL idle_timeout got=0 exp=1"); end
        checks++; if (sdb !== 64'h0) begin errors++; $display("FAIL idle_sd got=%h exp=0", sdb); end
        checks++; if (wsb !== WS_PAT) begin errors++; $display("FAIL idle_ws got=%h exp=%h", wsb, WS_PAT); end
        checks++; if (und !== 1'b1) begin errors++; $display("FAIL idle_underrun got=%b exp=1", und); end
    endtask

    task automatic test_sample();
        logic [63:0] sdb, wsb; logic und; bit ok; int o;
        o = ovr2;
        pulse(0, 24'hA5F00F, 24'h5A0FF0);
        capture(0, sdb, wsb, und, ok);
        checks++;
        if (!ok || sdb !== 64'h52F8_0780_2D07_F800) begin
            errors++; $display("FAIL sample_data ok=%b got=%h exp=52f807802d07f800", ok, sdb);
        end
        checks++; if (sdb[62:39] !== 24'hA5F00F || sdb[30:7] !== 24'h5A0FF0) begin
            errors++; $display("FAIL sample_deser left=%h right=%h exp a5f00f/5a0ff0", sdb[62:39], sdb[30:7]);
        end
        checks++; if (wsb !== WS_PAT) begin errors++; $display("FAIL sample_ws got=%h exp=%h", wsb, WS_PAT); end
        checks++; if (und !== 1'b0) begin errors++; $display("FAIL sample_underrun got=%b exp=0", und); end
        checks++; if (ovr2 != o) begin errors++; $display("FAIL sample_overrun got=%0d exp=%0d", ovr2, o); end
    endtask

    task automatic test_load_collision();
        logic [63:0] sdb, wsb; logic und; bit ok; int o;
        o = ovr2;
        @(negedge clk);
        pulse(0, 24'h123456, 24'h123456);  // sampled on the load edge
        capture(0, sdb, wsb, und, ok);
        checks++;
        if (!ok || sdb !== exp_frame(24'hA5F00F, 24'h5A0FF0)) begin
            errors++; $display("FAIL collide_old ok=%b got=%h exp=%h", ok, sdb, exp_frame(24'hA5F00F, 24'h5A0FF0));
        end
        checks++; if (und !== 1'b1) begin errors++; $display("FAIL collide_underrun got=%b exp=1", und); end
        capture(0, sdb, wsb, und, ok);
        checks++;
        if (!ok || sdb !== 64'h091A_2B00_091A_2B00) begin
            errors++; $display("FAIL collide_new ok=%b got=%h exp=091a2b00091a2b00", ok, sdb);
        end
        checks++; if (und !== 1'b0) begin errors++; $display("FAIL collide_new_underrun got=%b exp=0", und); end
        checks++; if (ovr2 != o) begin errors++; $display("FAIL collide_overrun got=%0d exp=%0d", ovr2, o); end
    endtask

    task automatic test_overrun();
        logic [63:0] sdb, wsb; logic und; bit ok; int o, n;
        o = ovr2; n = 0;
        while (!if2.frame_o && n < 600) begin @(negedge clk); n++; end
        checks++; if (n >= 600) begin errors++; $display("FAIL overrun_wait got=timeout exp=frame"); end
        pulse(0, 24'h000001, 24'h000001);
        repeat (10) @(negedge clk);
        pulse(0, 24'h7FFFFF, 24'h7FFFFF);
        capture(0, sdb, wsb, und, ok);
        checks++; if (ovr2 != o + 1) begin errors++; $display("FAIL overrun_count got=%0d exp=%0d", ovr2 - o, 1); end
        checks++;
        if (!ok || sdb !== exp_frame(24'h7FFFFF, 24'h7FFFFF)) begin
            errors++; $display("FAIL overrun_data ok=%b got=%h exp=%h", ok, sdb, exp_frame(24'h7FFFFF, 24'h7FFFFF));
        end
        checks++; if (und !== 1'b0) begin errors++; $display("FAIL overrun_underrun got=%b exp=0", und); end
    endtask

    task automatic test_repeat();
        logic [63:0] sdb, wsb; logic und; bit ok;
        pulse(0, 24'h800000, 24'h800000);
        for (int f = 1; f <= 3; f++) begin
            capture(0, sdb, wsb, und, ok);
            checks++;
            if (!ok || sdb !== 64'h4000_0000_4000_0000) begin
                errors++; $display("FAIL repeat_data frame%0d ok=%b got=%h exp=4000000040000000", f, ok, sdb);
            end
            checks++;
            if (und !== (f > 1)) begin errors++; $display("FAIL repeat_underrun frame%0d got=%b exp=%b", f, und, f > 1); end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] sdb, wsb; logic und; bit ok; int n; logic [5:0] o;
        @(negedge clk);
        rst1 = 1'b0;
        pulse(1, 24'h111111, 24'hFFFFFF);
        n = 0;
        while (!if1.frame_o && n < 600) begin @(negedge clk); n++; end
        checks++; if (n >= 600) begin errors++; $display("FAIL mid_wait got=timeout exp=frame"); end
        repeat (80) @(negedge clk);  // b = 40, right[16] on the line
        checks++;
        if (if1.i2s_sd !== 1'b1 || if1.i2s_ws !== 1'b1 || if1.i2s_sck !== 1'b0) begin
            errors++; $display("FAIL mid_b40 sd=%b ws=%b sck=%b exp sd=1 ws=1 sck=0", if1.i2s_sd, if1.i2s_ws, if1.i2s_sck);
        end
        rst1 = 1'b1;
        @(negedge clk);
        o = {if1.i2s_sck, if1.i2s_ws, if1.i2s_sd, if1.frame_o, if1.underrun_o, if1.overrun_o};
        checks++; if (o !== 6'b0) begin errors++; $display("FAIL mid_reset_outputs got=%b exp=000000", o); end
        rst1 = 1'b0;
        @(negedge clk);
        checks++;
        if (if1.i2s_sck !== 1'b1 || if1.frame_o !== 1'b0) begin
            errors++; $display("FAIL mid_cycle1 sck=%b frame=%b exp sck=1 frame=0", if1.i2s_sck, if1.frame_o);
        end
        @(negedge clk);
        checks++;
        if (if1.i2s_sck !== 1'b0 || if1.frame_o !== 1'b1 || if1.underrun_o !== 1'b1) begin
            errors++; $display("FAIL mid_cycle2 sck=%b frame=%b under=%b exp 0/1/1", if1.i2s_sck, if1.frame_o, if1.underrun_o);
        end
        capture(1, sdb, wsb, und, ok);
        checks++;
        if (!ok || sdb !== 64'h0 || wsb !== WS_PAT) begin
            errors++; $display("FAIL mid_restart_frame ok=%b sd=%h ws=%h exp sd=0 ws=%h", ok, sdb, wsb, WS_PAT);
        end
    endtask

    initial begin
        if1.audio_i = '0; if1.valid_i = 1'b0;
        if2.audio_i = '0; if2.valid_i = 1'b0;
        test_reset();
        test_idle_frame();
        test_sample();
        test_load_collision();
        test_overrun();
        test_repeat();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sid_i2s_tx.md
Name: sid_i2s_tx

Overview:
- I2S transmitter that serializes the stereo SID mix (sid::audio_t, 24-bit signed per channel) to an external DAC.
- Sits downstream of the SID API block's audio output, which publishes one new stereo sample per SID sample period.
- Generates SCK and WS itself (I2S master). Double-buffered, so a sample can arrive at any time relative to the frame.

Parameters:
- BCLK_DIV, 2: clk cycles per SCK half-period; minimum 1. SCK period is 2*BCLK_DIV clk cycles.
- FRAME_BITS, 64: SCK periods per stereo frame (32 per channel). Fixed; included for documentation only.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- audio_i  input  sid::audio_t  stereo sample; .left and .right are 24-bit signed.
- valid_i  input  1  one-cycle strobe; audio_i is valid in that cycle.
- i2s_sck  output  1  bit clock.
- i2s_ws  output  1  word select; 0 = left, 1 = right.
- i2s_sd  output  1  serial data, MSB first.
- frame_o  output  1  one-cycle strobe when the holding register is loaded into the shifter.
- underrun_o  output  1  one-cycle strobe, coincident with frame_o, when the loaded sample was stale.
- overrun_o  output  1  one-cycle strobe when valid_i overwrites a fresh, unconsumed sample.

Behaviour:
- Reset values:
  - Outputs: i2s_sck=0, i2s_ws=0, i2s_sd=0, frame_o=0, underrun_o=0, overrun_o=0.
  - Internal: div_cnt=0, bit index b=63, holding register=0, fresh=0, shifter=0.
  - Reset asserted mid-frame aborts the frame immediately; the next cycle shows reset values.
- SCK generation:
  - div_cnt counts 0..BCLK_DIV-1. In the cycle where div_cnt==BCLK_DIV-1, i2s_sck toggles and div_cnt returns to 0.
  - The first toggle after reset is a rising edge, at clk cycle BCLK_DIV.
- Falling-edge work (the cycle in which i2s_sck goes 1->0), all in that same cycle:
  - b advances modulo 64.
  - i2s_sd and i2s_ws update.
  - The DAC samples on the rising edge.
- Frame layout by b:
  - b0 = 0.
  - b1..b24 = left[23:0], MSB first.
  - b25..b31 = 0.
  - b32 = 0.
  - b33..b56 = right[23:0].
  - b57..b63 = 0.
- WS timing:
  - i2s_ws=1 for b in 31..62; 0 for b=63 and b in 0..30.
  - This gives the standard I2S one-bit lead before each MSB.
- Shifter load:
  - On the falling edge that sets b=0, the 64-bit shifter loads {1'b0, left, 7'b0, 1'b0, right, 7'b0} from the holding register.
  - frame_o pulses in that cycle. On each later falling edge the shifter shifts left by one; i2s_sd is the shifter MSB.
- Holding register:
  - valid_i writes audio_i to the holding register and sets fresh=1.
  - A load clears fresh.
  - If fresh=0 at load: the previous sample is repeated and underrun_o pulses.
- Simultaneous valid_i and load:
  - The load takes the old holding value (no bypass); underrun_o is judged on the old fresh.
  - The new sample is then stored with fresh=1 and is not an overrun.
- Overrun: valid_i while fresh=1 and not in a load cycle overwrites the holding register and pulses overrun_o.
- Latency:
  - A sample written with fresh=0 first drives the left MSB one SCK period after the next b=0 edge.
  - Frame length is 128*BCLK_DIV clk cycles.
- First frame after reset:
  - b=0 at clk cycle 2*BCLK_DIV.
  - It transmits zeros unless valid_i has arrived earlier (underrun_o pulses if not).

Decomposition:
- sid package additions: I2S_FRAME_BITS=64, I2S_SLOT_BITS=32, I2S_SAMPLE_BITS=24.
- audio_t reused unchanged.
- One natural sub-module: sid_i2s_sckgen (divider; outputs sck plus one-cycle fall_o/rise_o strobes).
- sid_i2s_tx contains the holding register, bit counter and shifter.

Test Plan:
- Reset then idle, BCLK_DIV=2:
  - First rising edge of i2s_sck at cycle 2; frame_o and underrun_o pulse at cycle 4.
  - i2s_sd stays 0 and i2s_ws follows the 31..62 pattern.
- valid_i with left=24'hA5F00F, right=24'h5A0FF0 before a frame:
  - Bench deserializes on rising edges and reads back both values exactly.
  - Pad bits are 0 and underrun_o stays 0 on that frame.
- valid_i asserted in the exact load cycle with new value 24'h123456 (both channels):
  - The current frame sends the old value and underrun_o pulses (fresh was 0).
  - The next frame sends 24'h123456 with no overrun_o.
- Two valid_i pulses within one frame (24'h000001, then 24'h7FFFFF):
  - overrun_o pulses once; the next frame carries 24'h7FFFFF.
- No valid_i for 3 frames after one sample 24'h800000:
  - Frames 2 and 3 repeat 24'h800000, each with frame_o and underrun_o pulses.
- rst asserted at b=40 with BCLK_DIV=1:
  - All outputs are 0 on the next cycle.
  - After release, the frame restarts with b=0 at cycle 2 and the holding register is 0.
